// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shift modes and a reference shift model for the barrel shifter
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } mode_t;

    // Single-step model on an n-bit word held in the low bits of a 64-bit value.
    function automatic logic [63:0] ref_shift(input logic [63:0] data, input int unsigned amt,
                                              input mode_t mode, input int unsigned n);
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] r;
        mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        d    = data & mask;
        case (mode)
            SLL: r = (d << amt) & mask;
            SRL: r = d >> amt;
            SRA: begin
                r = d >> amt;
                if (d[n-1]) r = r | (mask & ~(mask >> amt));
            end
            default: r = (amt == 0) ? d : (((d << amt) | (d >> (n - amt))) & mask);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one combinational barrel stage: shift by DIST or pass through
module shift_stage
    import shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int DIST = 1
) (
    input  logic [N-1:0] data_i,
    input  logic         en_i,
    input  mode_t        mode_i,
    input  logic         sign_i,
    output logic [N-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (mode_i)
                SLL:     data_o = {data_i[N-DIST-1:0], {DIST{1'b0}}};
                SRL:     data_o = {{DIST{1'b0}}, data_i[N-1:DIST]};
                SRA:     data_o = {{DIST{sign_i}}, data_i[N-1:DIST]};
                ROL:     data_o = {data_i[N-DIST-1:0], data_i[N-1:N-DIST]};
                default: data_o = data_i;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log2(N)-stage valid/ready barrel shifter (SLL/SRL/SRA/ROL)
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [N-1:0]         up_data,
    input  logic [$clog2(N)-1:0] up_amt,
    input  mode_t                up_mode,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [N-1:0]         down_data
);

    localparam int AMT_W = $clog2(N);

    logic [AMT_W-1:0] valid_v;
    logic [AMT_W-1:0] take;
    logic             nxt_take;

    // A stage can load when it is empty or its word leaves this cycle; walking
    // from the output backwards lets bubbles collapse in one pass.
    always_comb begin
        take     = '0;
        nxt_take = down_ready;
        for (int k = AMT_W - 1; k >= 0; k--) begin
            take[k]  = !valid_v[k] || nxt_take;
            nxt_take = take[k];
        end
    end

    assign up_ready = take[0];

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int IW = AMT_W - k;

        logic [N-1:0]  in_data;
        logic [IW-1:0] in_amt;
        mode_t         in_mode;
        logic          in_sign;
        logic          in_valid;
        logic [N-1:0]  data_d;
        logic [N-1:0]  data_q;
        logic          valid_q;

        if (k == 0) begin : g_src
            assign in_data  = up_data;
            assign in_amt   = up_amt;
            assign in_mode  = up_mode;
            assign in_sign  = up_data[N-1];
            assign in_valid = up_valid;
        end else begin : g_src
            assign in_data  = g_stage[k-1].data_q;
            assign in_amt   = g_stage[k-1].g_side.amt_q;
            assign in_mode  = g_stage[k-1].g_side.mode_q;
            assign in_sign  = g_stage[k-1].g_side.sign_q;
            assign in_valid = g_stage[k-1].valid_q;
        end

        shift_stage #(
            .N    (N),
            .DIST (1 << k)
        ) u_shift (
            .data_i (in_data),
            .en_i   (in_amt[0]),
            .mode_i (in_mode),
            .sign_i (in_sign),
            .data_o (data_d)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (take[k]) begin
                valid_q <= in_valid;
                if (in_valid) data_q <= data_d;
            end
        end

        // Only the amount bits still to be consumed travel on; the sign is the
        // original operand MSB, never re-read from shifted data.
        if (k < AMT_W - 1) begin : g_side
            logic [IW-2:0] amt_q;
            mode_t         mode_q;
            logic          sign_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    amt_q  <= '0;
                    mode_q <= SLL;
                    sign_q <= 1'b0;
                end else if (take[k] && in_valid) begin
                    amt_q  <= in_amt[IW-1:1];
                    mode_q <= in_mode;
                    sign_q <= in_sign;
                end
            end
        end

        assign valid_v[k] = valid_q;
    end

    assign down_valid = valid_v[AMT_W-1];
    assign down_data  = g_stage[AMT_W-1].data_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - directed, stall, reset and random checks for the barrel shifter
module tb_pipelined_barrel_shifter;
    import shift_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        mode_t      m;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   start_rand = 1'b0;

    always #5 clk = ~clk;

    logic       d_uv, d_ur, d_dv, d_dr;
    logic [7:0] d_ud, d_dd;
    logic [2:0] d_ua;
    mode_t      d_um;

    pipelined_barrel_shifter #(.N(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (d_uv),
        .up_ready   (d_ur),
        .up_data    (d_ud),
        .up_amt     (d_ua),
        .up_mode    (d_um),
        .down_valid (d_dv),
        .down_ready (d_dr),
        .down_data  (d_dd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int         lat;
        logic [7:0] res;
        int         n;
        @(negedge clk);
        d_uv = 1'b1; d_ud = v.d; d_ua = v.a; d_um = v.m; d_dr = 1'b1;
        #1;
        n = 0;
        while (!d_ur && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk($sformatf("vec%0d_accept", i), 64'(d_ur), 64'd1);
        @(negedge clk);
        d_uv = 1'b0;
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (d_dv) begin
                lat = c; res = d_dd; break;
            end
            @(negedge clk);
        end
        chk($sformatf("vec%0d_data", i), 64'(res), 64'(v.exp));
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int W  = (g == 0) ? 8 : (g == 1) ? 2 : 32;
        localparam int AW = $clog2(W);

        logic          uv, ur, dv, dr;
        logic [W-1:0]  ud, dd;
        logic [AW-1:0] ua;
        mode_t         um;
        bit            done = 1'b0;
        logic [63:0]   exp_q[$];

        pipelined_barrel_shifter #(.N(W)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (uv),
            .up_ready   (ur),
            .up_data    (ud),
            .up_amt     (ua),
            .up_mode    (um),
            .down_valid (dv),
            .down_ready (dr),
            .down_data  (dd)
        );

        initial begin
            int          acc;
            int          got;
            logic [63:0] e;
            uv = 1'b0; ud = '0; ua = '0; um = SLL; dr = 1'b0;
            acc = 0; got = 0;
            wait (start_rand);
            for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
                @(negedge clk);
                uv = (acc < 1000) && ($urandom_range(0, 3) != 0);
                ud = W'($urandom);
                ua = AW'($urandom);
                um = mode_t'($urandom_range(0, 3));
                dr = ($urandom_range(0, 3) != 0);
                #1;
                if (dv && dr) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("rand_n%0d_extra", W), 64'(dv), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rand_n%0d_word%0d", W, got), 64'(dd), e);
                    end
                    got++;
                end
                if (uv && ur) begin
                    exp_q.push_back(ref_shift(64'(ud), int'(ua), um, W));
                    acc++;
                end
            end
            uv = 1'b0;
            chk($sformatf("rand_n%0d_count", W), 64'(got), 64'd1000);
            done = 1'b1;
        end
    end

    initial begin
        vec_t       tab[14];
        int         sidx[6];
        logic [7:0] sexp[6];
        int         sent, recv, held;
        bit         prev_stall, saw_full, ghost;
        logic [7:0] prev_dd;

        tab[0]  = '{8'hB6, 3'd3, SLL, 8'hB0};
        tab[1]  = '{8'h90, 3'd2, SRA, 8'hE4};
        tab[2]  = '{8'hF0, 3'd7, SRL, 8'h01};
        tab[3]  = '{8'h81, 3'd1, ROL, 8'h03};
        tab[4]  = '{8'hA5, 3'd0, SLL, 8'hA5};
        tab[5]  = '{8'hA5, 3'd0, SRL, 8'hA5};
        tab[6]  = '{8'hA5, 3'd0, SRA, 8'hA5};
        tab[7]  = '{8'hA5, 3'd0, ROL, 8'hA5};
        tab[8]  = '{8'h7F, 3'd3, SRA, 8'h0F};
        tab[9]  = '{8'h96, 3'd5, ROL, 8'hD2};
        tab[10] = '{8'h01, 3'd7, SLL, 8'h80};
        tab[11] = '{8'h80, 3'd7, SRA, 8'hFF};
        tab[12] = '{8'h96, 3'd4, SRL, 8'h09};
        tab[13] = '{8'hA5, 3'd4, ROL, 8'h5A};
        sidx = '{0, 1, 2, 3, 9, 11};
        sexp = '{8'hB0, 8'hE4, 8'h01, 8'h03, 8'hD2, 8'hFF};

        rst = 1'b1;
        d_uv = 1'b0; d_ud = '0; d_ua = '0; d_um = SLL; d_dr = 1'b1;
        #3;
        chk("reset_down_valid", 64'(d_dv), 64'd0);
        chk("reset_down_data", 64'(d_dd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_up_ready", 64'(d_ur), 64'd1);

        for (int i = 0; i < 14; i++) run_vec(i, tab[i]);

        sent = 0; recv = 0; prev_stall = 0; saw_full = 0; prev_dd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            d_dr = !(c >= 2 && c <= 8);
            d_uv = (sent < 6);
            if (sent < 6) begin
                d_ud = tab[sidx[sent]].d; d_ua = tab[sidx[sent]].a; d_um = tab[sidx[sent]].m;
            end
            #1;
            held = sent - recv;
            if (d_uv) chk($sformatf("stall_up_ready_c%0d", c), 64'(d_ur), 64'((held < 3) || d_dr));
            if (d_uv && !d_ur) saw_full = 1;
            if (prev_stall) begin
                chk($sformatf("stall_hold_valid_c%0d", c), 64'(d_dv), 64'd1);
                chk($sformatf("stall_hold_data_c%0d", c), 64'(d_dd), 64'(prev_dd));
            end
            if (d_dv && d_dr) begin
                if (recv < 6) chk($sformatf("stall_out%0d", recv), 64'(d_dd), 64'(sexp[recv]));
                else          chk("stall_extra_word", 64'(d_dv), 64'd0);
                recv++;
            end
            prev_stall = d_dv && !d_dr;
            prev_dd = d_dd;
            if (d_uv && d_ur) sent++;
        end
        d_uv = 1'b0;
        chk("stall_full_seen", 64'(saw_full), 64'd1);
        chk("stall_count", 64'(recv), 64'd6);

        d_dr = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            d_uv = 1'b1; d_ud = tab[j].d; d_ua = tab[j].a; d_um = tab[j].m;
        end
        @(negedge clk);
        d_uv = 1'b0;
        #1;
        chk("rst_pre_valid", 64'(d_dv), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(d_dv), 64'd0);
        chk("rst_async_data", 64'(d_dd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        d_dr = 1'b1;
        #1;
        chk("rst_release_up_ready", 64'(d_ur), 64'd1);
        ghost = d_dv;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk); #1;
            ghost = ghost | d_dv;
        end
        chk("rst_no_old_word", 64'(ghost), 64'd0);

        start_rand = 1'b1;
        for (int t = 0; t < 30000; t++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
            @(negedge clk);
        end
        chk("rand_all_done", 64'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
